// File: rtl/hamming_enc_seq.sv
// rtl/hamming_enc_seq.sv - SECDED(16,11) Hamming encode sequencer driving a shared 8-bit ALU
// Computes p1/p2/p4/p8, packs LSW/MSW, then folds in the overall parity p0.
module hamming_enc_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] enc_out,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_ina,
  output logic [7:0]  alu_inb,
  output logic        alu_sc_in,
  input  logic [7:0]  alu_rslt
);

  localparam logic [3:0] OP_P0  = 4'b1000;
  localparam logic [3:0] OP_P1  = 4'b1001;
  localparam logic [3:0] OP_P2  = 4'b1010;
  localparam logic [3:0] OP_P4  = 4'b1011;
  localparam logic [3:0] OP_P8  = 4'b1100;
  localparam logic [3:0] OP_PKL = 4'b1101;
  localparam logic [3:0] OP_PKM = 4'b1110;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] S_P1  = 3'd1;
  localparam logic [2:0] S_P2  = 3'd2;
  localparam logic [2:0] S_P4  = 3'd3;
  localparam logic [2:0] S_P8  = 3'd4;
  localparam logic [2:0] S_PKL = 3'd5;
  localparam logic [2:0] S_PKM = 3'd6;
  localparam logic [2:0] S_P0  = 3'd7;

  logic [2:0]  r_state;
  logic [10:0] r_data;
  logic        r_p1;
  logic        r_p2;
  logic        r_p4;
  logic        r_p8;
  logic [7:0]  r_lsw;
  logic [7:0]  r_msw;
  logic [15:0] r_enc;
  logic        r_done;

  logic [7:0]  w_d_lo;
  logic [7:0]  w_d_hi;
  logic        w_fire;

  assign w_d_lo    = r_data[7:0];
  assign w_d_hi    = {5'b0, r_data[10:8]};
  assign w_fire    = alu_req & alu_gnt;

  assign busy      = (r_state != IDLE);
  assign alu_req   = (r_state != IDLE);
  assign done      = r_done;
  assign enc_out   = r_enc;
  assign alu_sc_in = 1'b0;

  // Operands are a pure function of state and latched data, so they stay stable across stalls.
  always_comb begin
    alu_op  = 4'b0000;
    alu_ina = 8'h00;
    alu_inb = 8'h00;
    case (r_state)
      S_P1: begin
        alu_op  = OP_P1;
        alu_ina = w_d_lo;
        alu_inb = w_d_hi;
      end
      S_P2: begin
        alu_op  = OP_P2;
        alu_ina = w_d_lo;
        alu_inb = w_d_hi;
      end
      S_P4: begin
        alu_op  = OP_P4;
        alu_ina = w_d_lo;
        alu_inb = w_d_hi;
      end
      S_P8: begin
        alu_op  = OP_P8;
        alu_ina = w_d_lo;
        alu_inb = w_d_hi;
      end
      S_PKL: begin
        alu_op  = OP_PKL;
        alu_ina = w_d_lo;
        alu_inb = 8'h00;
      end
      S_PKM: begin
        alu_op  = OP_PKM;
        alu_ina = w_d_lo;
        alu_inb = w_d_hi;
      end
      S_P0: begin
        alu_op  = OP_P0;
        alu_ina = r_lsw;
        alu_inb = r_msw;
      end
      default: begin
        alu_op  = 4'b0000;
        alu_ina = 8'h00;
        alu_inb = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_data  <= 11'h000;
      r_p1    <= 1'b0;
      r_p2    <= 1'b0;
      r_p4    <= 1'b0;
      r_p8    <= 1'b0;
      r_lsw   <= 8'h00;
      r_msw   <= 8'h00;
      r_enc   <= 16'h0000;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_data  <= data_in;
            r_state <= S_P1;
          end
        end
        S_P1: begin
          if (w_fire) begin
            r_p1    <= alu_rslt[0];
            r_state <= S_P2;
          end
        end
        S_P2: begin
          if (w_fire) begin
            r_p2    <= alu_rslt[0];
            r_state <= S_P4;
          end
        end
        S_P4: begin
          if (w_fire) begin
            r_p4    <= alu_rslt[0];
            r_state <= S_P8;
          end
        end
        S_P8: begin
          if (w_fire) begin
            r_p8    <= alu_rslt[0];
            r_state <= S_PKL;
          end
        end
        S_PKL: begin
          // Bit 0 is left clear so the final ALU parity pass sees only the other 15 bits.
          if (w_fire) begin
            r_lsw   <= {alu_rslt[7:5], r_p4, alu_rslt[3], r_p2, r_p1, 1'b0};
            r_state <= S_PKM;
          end
        end
        S_PKM: begin
          if (w_fire) begin
            r_msw   <= {alu_rslt[7:1], r_p8};
            r_state <= S_P0;
          end
        end
        S_P0: begin
          if (w_fire) begin
            r_enc   <= {r_msw, r_lsw[7:1], alu_rslt[0]};
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_enc_seq.sv
// tb/tb_hamming_enc_seq.sv - self-checking bench for hamming_enc_seq
// Includes a behavioural ALU and a position-based Hamming reference model.
module tb_hamming_enc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] data_in;
  logic        busy;
  logic        done;
  logic [15:0] enc_out;
  logic        alu_req;
  logic        alu_gnt;
  logic [3:0]  alu_op;
  logic [7:0]  alu_ina;
  logic [7:0]  alu_inb;
  logic        alu_sc_in;
  logic [7:0]  alu_rslt;

  int n_checks = 0;
  int n_errors = 0;

  hamming_enc_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .enc_out   (enc_out),
    .alu_req   (alu_req),
    .alu_gnt   (alu_gnt),
    .alu_op    (alu_op),
    .alu_ina   (alu_ina),
    .alu_inb   (alu_inb),
    .alu_sc_in (alu_sc_in),
    .alu_rslt  (alu_rslt)
  );

  always #5 clk = ~clk;

  // Data bits fill the non-power-of-two positions in order; pK covers positions with bit K set.
  function automatic logic [15:0] ref_enc(input logic [10:0] d);
    logic [15:0] w;
    int j;
    w = 16'h0000;
    j = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        w[pos] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      logic p;
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if (((pos >> k) & 1) == 1) p = p ^ w[pos];
      w[1 << k] = p;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  always_comb begin
    logic [15:0] e;
    e = ref_enc({alu_inb[2:0], alu_ina});
    alu_rslt = 8'h00;
    case (alu_op)
      4'b1000: alu_rslt = {7'b0, (^alu_ina) ^ (^alu_inb)};
      4'b1001: alu_rslt = {alu_ina[7:1], e[1]};
      4'b1010: alu_rslt = {alu_ina[7:1], e[2]};
      4'b1011: alu_rslt = {alu_ina[7:1], e[4]};
      4'b1100: alu_rslt = {alu_ina[7:1], e[8]};
      4'b1101: alu_rslt = e[7:0] & 8'hE8;
      4'b1110: alu_rslt = e[15:8] & 8'hFE;
      default: alu_rslt = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 of an encode; returns in the done cycle (or on timeout).
  // mode 0: grant always; 1: random grant/start/data; 2: stall 3 cycles in S_P4; 3: stray start at cycle 3
  task automatic wait_done(input int mode, output int lat, output int stalls);
    logic [3:0] exp_ops [7];
    int k;
    exp_ops = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h8};
    k = 0;
    lat = 1;
    stalls = 0;
    while (!done && lat < 100) begin
      alu_gnt = 1'b1;
      if (mode == 1) begin
        alu_gnt = ($urandom_range(0, 2) != 0);
        start   = $urandom_range(0, 1) == 1;
        data_in = 11'($urandom);
      end else if (mode == 2) begin
        alu_gnt = !(lat >= 3 && lat <= 5);
      end else if (mode == 3) begin
        start   = (lat == 3);
        data_in = ~data_in;
      end
      if (k < 7) begin
        check("busy_run", busy, 1'b1);
        check("alu_op", alu_op, exp_ops[k]);
      end
      if (alu_req && !alu_gnt) stalls++;
      if (alu_req && alu_gnt) k++;
      tick();
      lat++;
    end
    check("done_seen", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    alu_gnt = 1'b1;
  endtask

  task automatic run_enc(input logic [10:0] d, input int mode, output logic [15:0] enc, output int lat);
    int stalls;
    start   = 1'b1;
    data_in = d;
    tick();
    start = 1'b0;
    wait_done(mode, lat, stalls);
    start = 1'b0;
    enc = enc_out;
    check("enc_ref", enc_out, ref_enc(d));
    check("latency", lat, 8 + stalls);
    tick();
    check("done_pulse", done, 1'b0);
    check("no_restart", busy, 1'b0);
  endtask

  initial begin
    logic [15:0] enc;
    int lat;
    int lat2;
    int st;
    logic [10:0] d;

    reset   = 1'b1;
    start   = 1'b0;
    data_in = 11'h000;
    alu_gnt = 1'b1;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_req", alu_req, 1'b0);
    check("rst_enc", enc_out, 16'h0000);
    check("rst_op", alu_op, 4'h0);
    check("sc_in", alu_sc_in, 1'b0);
    reset = 1'b0;
    tick();

    run_enc(11'h001, 0, enc, lat);
    check("enc_001", enc, 16'h000F);
    check("lat_001", lat, 8);
    run_enc(11'h400, 0, enc, lat);
    check("enc_400", enc, 16'h8117);
    run_enc(11'h7FF, 0, enc, lat);
    check("enc_7ff", enc, 16'hFFFF);
    run_enc(11'h000, 0, enc, lat);
    check("enc_000", enc, 16'h0000);

    run_enc(11'h2A5, 2, enc, lat);
    check("lat_stall", lat, 11);

    run_enc(11'h135, 3, enc, lat);
    check("enc_ign_start", enc, ref_enc(11'h135));

    // Grant activity while idle must not start anything.
    for (int i = 0; i < 4; i++) begin
      alu_gnt = i[0];
      tick();
      check("idle_req", alu_req, 1'b0);
      check("idle_busy", busy, 1'b0);
    end
    alu_gnt = 1'b1;

    // Async reset while in S_PKM.
    start   = 1'b1;
    data_in = 11'h5C3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_op", alu_op, 4'hE);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_req", alu_req, 1'b0);
    check("arst_enc", enc_out, 16'h0000);
    check("arst_done", done, 1'b0);
    tick();
    check("arst_done2", done, 1'b0);
    reset = 1'b0;
    tick();
    run_enc(11'h5C3, 0, enc, lat);

    // Back-to-back: start held through the done cycle.
    start   = 1'b1;
    data_in = 11'h0F0;
    tick();
    data_in = 11'h70E;
    wait_done(0, lat, st);
    check("b2b_enc1", enc_out, ref_enc(11'h0F0));
    check("b2b_lat1", lat, 8);
    tick();
    start = 1'b0;
    check("b2b_busy2", busy, 1'b1);
    wait_done(0, lat2, st);
    check("b2b_enc2", enc_out, ref_enc(11'h70E));
    check("b2b_gap", lat2, 8);
    tick();
    check("b2b_end", done, 1'b0);

    for (int i = 0; i < 40; i++) begin
      d = 11'($urandom);
      run_enc(d, 1, enc, lat);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        alu_gnt = $urandom_range(0, 1) == 1;
        tick();
        check("rnd_idle_req", alu_req, 1'b0);
      end
      alu_gnt = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hamming_enc_seq.md
Name: hamming_enc_seq

Overview:
- Sequencer that encodes one 11-bit data word into a 16-bit SECDED Hamming word by issuing a fixed series of operations to the shared 8-bit ALU.
- The ALU provides the parity (p0/p1/p2/p4/p8) and packing ops.
- Sits between the program-level encode request and the ALU.
- Requests the ALU through a req/gnt pair so the ALU stays shared with the core datapath.

Parameters:
- OP_P0, 4'b1000, ALU op: overall parity (^inA ^ ^inB)
- OP_P1, 4'b1001, ALU op: p1 parity
- OP_P2, 4'b1010, ALU op: p2 parity
- OP_P4, 4'b1011, ALU op: p4 parity
- OP_P8, 4'b1100, ALU op: p8 parity
- OP_PKL, 4'b1101, ALU op: package LSW
- OP_PKM, 4'b1110, ALU op: package MSW

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  encode request; sampled only in IDLE
- data_in  in  11  d[10:0]; latched when start is accepted
- busy  out  1  high from the cycle after start acceptance until the op sequence completes
- done  out  1  one-cycle pulse when enc_out is updated
- enc_out  out  16  encoded word; held until the next completion
- alu_req  out  1  ALU request; high in every op state
- alu_gnt  in  1  ALU grant; an op completes only in a cycle with alu_req & alu_gnt
- alu_op  out  4  ALU command
- alu_ina  out  8  ALU operand A
- alu_inb  out  8  ALU operand B
- alu_sc_in  out  1  tied 0
- alu_rslt  in  8  combinational ALU result for the current alu_op/ina/inb

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, alu_req=0, enc_out=16'h0000; internal data/parity/lsw/msw registers cleared.
- Encoding layout (enc bit = Hamming position):
  - p0 at bit 0; p1, p2, p4, p8 at bits 1, 2, 4, 8.
  - d0..d10 at bits 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15.
  - LSW = {d3, d2, d1, p4, d0, p2, p1, p0}.
  - MSW = {d10..d4, p8}.
- States: IDLE -> S_P1 -> S_P2 -> S_P4 -> S_P8 -> S_PKL -> S_PKM -> S_P0 -> IDLE.
  - An op state advances only on a clock edge where alu_gnt=1.
  - With alu_gnt=0 the state holds, alu_op/ina/inb hold stable, and nothing is captured.
- IDLE:
  - alu_req=0, alu_op=0, ina=inb=0.
  - start=1 latches data_in and moves to S_P1; busy=1 the next cycle.
- Operand and capture rules:
  - S_P1, S_P2, S_P4, S_P8: ina = d[7:0], inb = {5'b0, d[10:8]}, op = the matching OP_Px. Capture px <= alu_rslt[0].
  - S_PKL: op = OP_PKL, ina = d[7:0], inb = 0. lsw <= {alu_rslt[7:5], p4, alu_rslt[3], p2, p1, 1'b0}.
  - S_PKM: op = OP_PKM, ina = d[7:0], inb = {5'b0, d[10:8]}. msw <= {alu_rslt[7:1], p8}.
  - S_P0: op = OP_P0, ina = lsw, inb = msw. On grant: enc_out <= {msw, lsw[7:1], alu_rslt[0]}, done <= 1, state <= IDLE, busy <= 0.
- Latency: with alu_gnt held at 1, start in cycle 0 -> done and new enc_out in cycle 8. Each stall cycle adds 1.
- done is high for exactly one cycle, the same cycle busy drops.
  - start in that cycle is accepted (back-to-back encodes allowed).
- start while busy is ignored; data_in changes while busy have no effect.
- alu_gnt toggling while not requesting is ignored.

Test Plan:
- data_in=11'h001, gnt=1 -> done at cycle 8, enc_out=16'h000F; alu_op sequence 9, A, B, C, D, E, 8 in cycles 1-7.
- data_in=11'h400 -> enc_out=16'h8117. data_in=11'h7FF -> 16'hFFFF. data_in=11'h000 -> 16'h0000.
- gnt=0 for 3 cycles while in S_P4 -> alu_op holds 4'b1011 for 4 cycles; done at cycle 11; enc_out still correct.
- start pulsed again at cycle 3 with different data -> ignored; result matches the first data; no extra done.
- reset asserted in S_PKM -> same cycle (async): busy=0, alu_req=0, enc_out=0, no done; a later start encodes correctly.
- start held high through done -> second encode begins in the done cycle; two done pulses exactly 8 cycles apart.
